// File: rtl/tape_arbiter_if.sv
// CPU cell-access bus of the data-tape arbiter: req/ack handshake with byte read/write.
// master = CPU side, slave = arbiter side.
interface tape_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/tape_arbiter.sv
// Shares the 16K x 16 data-tape SPRAM between the VGA reader, the CPU and a tape-clear engine.
// Define TAPE_ARB_STARVE_EN to let a starved CPU request steal a cycle during the display area.
module tape_arbiter #(
    parameter int unsigned STARVE_LIMIT = 64,
    parameter int unsigned CLEAR_WORDS  = 16384
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_display_area,
    input  logic [14:0]   vga_addr,
    output logic [7:0]    vga_cell,
    tape_arbiter_if.slave cpu_bus,
    input  logic          clear_req,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [13:0]   mem_addr,
    output logic [3:0]    mem_we,
    output logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout
);
    localparam int unsigned CntW = (CLEAR_WORDS > 1) ? $clog2(CLEAR_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StCpuIssue, StCpuDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] clear_cnt_q, clear_cnt_d;
    logic            clear_busy_q, clear_busy_d;
    logic            clear_done_q, clear_done_d;
    logic            vga_own, vga_own_q, vga_sel_q;
    logic [7:0]      vga_hold_q, cpu_rdata_q;
    logic            cpu_grant, clear_own, steal, clear_last;
    logic [7:0]      vga_byte, cpu_byte;

`ifdef TAPE_ARB_STARVE_EN
    localparam int unsigned StW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [StW-1:0] starve_q, starve_d;
    logic           blocked;

    always_comb begin
        blocked  = cpu_bus.cpu_req && (state_q == StIdle) && in_display_area;
        steal    = blocked && (starve_q >= StW'(STARVE_LIMIT));
        starve_d = starve_q;
        if (cpu_grant || cpu_bus.cpu_ack) begin
            starve_d = '0;
        end else if (blocked) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign steal = 1'b0;
`endif

    assign clear_last = (clear_cnt_q == CntW'(CLEAR_WORDS - 1));

    // Ownership is only arbitrated in IDLE; a started CPU access keeps the port through ISSUE.
    always_comb begin
        cpu_grant = 1'b0;
        clear_own = 1'b0;
        vga_own   = 1'b0;
        if (state_q == StIdle) begin
            if (steal) begin
                cpu_grant = 1'b1;
            end else if (in_display_area) begin
                vga_own = 1'b1;
            end else if (clear_busy_q) begin
                clear_own = 1'b1;
            end else if (cpu_bus.cpu_req) begin
                cpu_grant = 1'b1;
            end else begin
                vga_own = 1'b1;
            end
        end else if (state_q == StCpuDone) begin
            vga_own = 1'b1;
        end
    end

    always_comb begin
        mem_addr = vga_addr[13:0];
        mem_we   = 4'b0000;
        mem_din  = {cpu_bus.cpu_wdata, cpu_bus.cpu_wdata};
        if (clear_own) begin
            mem_addr = 14'(clear_cnt_q);
            mem_we   = 4'b1111;
            mem_din  = '0;
        end else if (cpu_grant) begin
            mem_addr = cpu_bus.cpu_addr[13:0];
            if (cpu_bus.cpu_we) begin
                mem_we = cpu_bus.cpu_addr[14] ? 4'b1100 : 4'b0011;
            end
        end else if (state_q == StCpuIssue) begin
            // Re-present the address so the read data lands in CPU_DONE.
            mem_addr = cpu_bus.cpu_addr[13:0];
        end
        if (!resetn) begin
            mem_we = 4'b0000;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (cpu_grant) state_d = StCpuIssue;
            StCpuIssue: state_d = StCpuDone;
            StCpuDone:  state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        clear_busy_d = clear_busy_q;
        clear_cnt_d  = clear_cnt_q;
        clear_done_d = 1'b0;
        if (!clear_busy_q) begin
            if (clear_req) begin
                clear_busy_d = 1'b1;
                clear_cnt_d  = '0;
            end
        end else if (clear_own) begin
            if (clear_last) begin
                clear_busy_d = 1'b0;
                clear_done_d = 1'b1;
                clear_cnt_d  = '0;
            end else begin
                clear_cnt_d = clear_cnt_q + 1'b1;
            end
        end
    end

    assign vga_byte   = vga_sel_q ? mem_dout[15:8] : mem_dout[7:0];
    assign cpu_byte   = cpu_bus.cpu_addr[14] ? mem_dout[15:8] : mem_dout[7:0];
    assign vga_cell   = vga_own_q ? vga_byte : vga_hold_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;

    assign cpu_bus.cpu_ack   = (state_q == StCpuDone);
    assign cpu_bus.cpu_rdata = (cpu_bus.cpu_ack && !cpu_bus.cpu_we) ? cpu_byte : cpu_rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            clear_cnt_q  <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            vga_own_q    <= 1'b0;
            vga_sel_q    <= 1'b0;
            vga_hold_q   <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            clear_cnt_q  <= clear_cnt_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            vga_own_q    <= vga_own;
            if (vga_own) begin
                vga_sel_q <= vga_addr[14];
            end
            vga_hold_q  <= vga_cell;
            cpu_rdata_q <= cpu_bus.cpu_rdata;
        end
    end
endmodule

// File: tb/tb_tape_arbiter.sv
// Directed self-checking bench for tape_arbiter with a behavioural 16K x 16 SPRAM model.
module tb_tape_arbiter;
    logic        clk;
    logic        resetn;
    logic        in_display_area;
    logic [14:0] vga_addr;
    logic [7:0]  vga_cell;
    logic        clear_req;
    logic        clear_busy;
    logic        clear_done;
    logic [13:0] mem_addr;
    logic [3:0]  mem_we;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    tape_arbiter_if bus ();

    tape_arbiter #(
        .STARVE_LIMIT (64),
        .CLEAR_WORDS  (16384)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .in_display_area (in_display_area),
        .vga_addr        (vga_addr),
        .vga_cell        (vga_cell),
        .cpu_bus         (bus),
        .clear_req       (clear_req),
        .clear_busy      (clear_busy),
        .clear_done      (clear_done),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:16383];

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (mem_we[n]) mem[mem_addr][4*n +: 4] <= mem_din[4*n +: 4];
        end
        mem_dout <= mem[mem_addr];
    end

    // Clear-write monitor: address sequence, display pauses and done pulses.
    int          wr_cnt, seq_err, disp_err, done_cnt;
    logic [13:0] exp_addr;

    always @(negedge clk) begin
        if (resetn) begin
            if (clear_done) done_cnt++;
            if (mem_we == 4'b1111) begin
                wr_cnt++;
                if (mem_addr != exp_addr || mem_din != 16'h0000) seq_err++;
                if (in_display_area) disp_err++;
                exp_addr = exp_addr + 14'd1;
            end
        end
    end

    int checks, errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_start(input logic we, input logic [14:0] addr, input logic [7:0] wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    // Counts cycles from the current one until ack; drops req in the ack cycle.
    task automatic wait_ack(input int bound, output int lat, output logic [7:0] rdata);
        lat = 0;
        #1;
        while (!bus.cpu_ack && lat < bound) begin
            tick();
            lat++;
        end
        rdata = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
    endtask

    task automatic reset_mon();
        wr_cnt   = 0;
        seq_err  = 0;
        disp_err = 0;
        done_cnt = 0;
        exp_addr = '0;
    endtask

    int         lat, cyc;
    logic [7:0] rd;
    logic       seen;

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        reset_mon();
        resetn          = 1'b0;
        in_display_area = 1'b0;
        vga_addr        = '0;
        clear_req       = 1'b0;
        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        repeat (3) tick();
        check("rst_vga_cell", 32'(vga_cell), 0);
        check("rst_ack", 32'(bus.cpu_ack), 0);
        check("rst_rdata", 32'(bus.cpu_rdata), 0);
        check("rst_busy", 32'(clear_busy), 0);
        check("rst_done", 32'(clear_done), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        resetn = 1'b1;
        tick();

        // CPU write to high byte of word 5, then reads of both bytes.
        cpu_start(1'b1, 15'h4005, 8'hA5);
        #1;
        check("wr_mem_we", 32'(mem_we), 32'hC);
        check("wr_mem_addr", 32'(mem_addr), 32'h0005);
        check("wr_mem_din", 32'(mem_din), 32'hA5A5);
        wait_ack(20, lat, rd);
        check("wr_lat", lat, 2);
        tick();
        check("wr_rdata_unchanged", 32'(bus.cpu_rdata), 0);
        cpu_start(1'b0, 15'h4005, 8'h00);
        wait_ack(20, lat, rd);
        check("rd_hi_lat", lat, 2);
        check("rd_hi_data", 32'(rd), 32'hA5);
        tick();
        check("rd_hold", 32'(bus.cpu_rdata), 32'hA5);
        cpu_start(1'b0, 15'h0005, 8'h00);
        wait_ack(20, lat, rd);
        check("rd_lo_data", 32'(rd), 32'h5F);
        tick();

        // VGA reads during the display area; CPU waits for it to end.
        in_display_area = 1'b1;
        vga_addr        = 15'h0005;
        tick();
        check("vga_lo", 32'(vga_cell), 32'h5F);
        vga_addr = 15'h4005;
        tick();
        check("vga_hi", 32'(vga_cell), 32'hA5);
        cpu_start(1'b0, 15'h0006, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cpu_ack) seen = 1'b1;
        end
        check("disp_no_ack", 32'(seen), 0);
        in_display_area = 1'b0;
        wait_ack(20, lat, rd);
        check("disp_end_lat", lat, 2);
        check("disp_end_data", 32'(rd), 32'h5C);
        tick();

        // Display held with CPU request held: steal after 64 blocked cycles, else wait.
        in_display_area = 1'b1;
        vga_addr        = 15'h4005;
        tick();
        cpu_start(1'b0, 15'h0006, 8'h00);
`ifdef TAPE_ARB_STARVE_EN
        wait_ack(200, lat, rd);
        check("steal_lat", lat, 66);
        check("steal_vga_hold", 32'(vga_cell), 32'hA5);
        check("steal_data", 32'(rd), 32'h5C);
        tick();
        in_display_area = 1'b0;
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.cpu_ack) seen = 1'b1;
        end
        check("nosteal_no_ack", 32'(seen), 0);
        in_display_area = 1'b0;
        wait_ack(20, lat, rd);
        check("nosteal_lat", lat, 2);
        check("nosteal_data", 32'(rd), 32'h5C);
`endif
        tick();

        // Full clear with display toggling.
        reset_mon();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_busy_set", 32'(clear_busy), 1);
        cyc = 0;
        while (!clear_done && cyc < 40000) begin
            tick();
            cyc++;
            in_display_area = ((cyc % 7) < 2);
        end
        in_display_area = 1'b0;
        check("clr_done_seen", 32'(clear_done), 1);
        check("clr_busy_low", 32'(clear_busy), 0);
        check("clr_writes", wr_cnt, 16384);
        check("clr_seq_err", seq_err, 0);
        check("clr_disp_err", disp_err, 0);
        repeat (5) tick();
        check("clr_done_pulses", done_cnt, 1);
        cpu_start(1'b0, 15'h7FFF, 8'h00);
        wait_ack(20, lat, rd);
        check("clr_rd_7fff", 32'(rd), 0);
        tick();

        // Simultaneous clear and CPU request: CPU first; a second clear_req is ignored.
        cpu_start(1'b1, 15'h0010, 8'h3C);
        check("sim_vga_cell", 32'(vga_cell), 0);
        reset_mon();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("sim_busy", 32'(clear_busy), 1);
        wait_ack(20, lat, rd);
        check("sim_lat", lat + 1, 2);
        check("sim_no_clear_yet", wr_cnt, 0);
        repeat (50) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cpu_start(1'b0, 15'h0010, 8'h00);
        wait_ack(40000, lat, rd);
        check("sim_ack_after_clear", 32'(clear_busy), 0);
        check("sim_rd_zero", 32'(rd), 0);
        check("sim_writes", wr_cnt, 16384);
        repeat (20) tick();
        check("sim_done_pulses", done_cnt, 1);
        check("sim_seq_err", seq_err, 0);

        // Reset in the middle of a clear.
        cpu_start(1'b1, 15'h0020, 8'h77);
        wait_ack(20, lat, rd);
        tick();
        cpu_start(1'b0, 15'h0020, 8'h00);
        wait_ack(20, lat, rd);
        check("pre_rst_rd", 32'(rd), 32'h77);
        vga_addr = 15'h0020;
        repeat (2) tick();
        check("pre_rst_vga", 32'(vga_cell), 32'h77);
        reset_mon();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cyc = 0;
        while (wr_cnt < 100 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("mid_clr_count", wr_cnt, 100);
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(clear_busy), 0);
        check("mid_rst_done", 32'(clear_done), 0);
        check("mid_rst_mem_we", 32'(mem_we), 0);
        check("mid_rst_vga", 32'(vga_cell), 0);
        check("mid_rst_rdata", 32'(bus.cpu_rdata), 0);
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();
        check("mid_rst_abandon", 32'(clear_busy), 0);
        check("mid_rst_no_done", done_cnt, 0);
        reset_mon();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cyc = 0;
        while (!clear_done && cyc < 20000) begin
            tick();
            cyc++;
        end
        check("reclr_done", 32'(clear_done), 1);
        check("reclr_writes", wr_cnt, 16384);
        check("reclr_seq_err", seq_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
